// File: rtl/oled_pkg.sv
// Shared definitions for the 6800-bus OLED responder:
// SSD1306 opcodes, parser state encoding and the two-byte-command lookup.
package oled_pkg;

  // Single-byte commands with side effects
  localparam logic [7:0] CMD_COL_LO      = 8'h00;  // 00-0F: column low nibble
  localparam logic [7:0] CMD_COL_HI      = 8'h10;  // 10-17: column high bits
  localparam logic [7:0] CMD_SET_PAGE    = 8'hB0;  // B0-B7: page select
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;

  // Commands that are followed by exactly one argument byte
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;

  // Parser state: waiting for an opcode, or waiting for its argument
  typedef enum logic {
    S_CMD = 1'b0,
    S_ARG = 1'b1
  } state_t;

  // True when the opcode consumes the next command byte as its argument
  function automatic logic has_arg(input logic [7:0] op);
    case (op)
      CMD_CLK_DIV, CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CHARGE_PUMP,
      CMD_COM_PINS, CMD_CONTRAST, CMD_PRECHARGE, CMD_VCOMH: has_arg = 1'b1;
      default:                                               has_arg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oled_bus_sync.sv
// Brings the asynchronous 6800 bus into the clk domain and produces a
// one-cycle strobe on each qualified falling edge of E (cs low, rw low).
// Every bus line passes through a meta/s1 flop pair; E gets an extra s2
// flop for edge detection. The strobe is held off after reset until E has
// been seen high, so a bus left mid-byte across reset cannot fake an edge.
module oled_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cs,
  input  logic       i_e,
  input  logic       i_rw,
  input  logic       i_dc,
  input  logic [7:0] i_data,
  output logic       o_strobe,
  output logic       o_dc,
  output logic [7:0] o_data,
  output logic       o_cs_s1,
  output logic       o_rw_s1,
  output logic       o_e_s1
);

  logic       r_cs_meta, r_cs_s1;
  logic       r_e_meta, r_e_s1, r_e_s2;
  logic       r_rw_meta, r_rw_s1;
  logic       r_dc_meta, r_dc_s1;
  logic [7:0] r_data_meta, r_data_s1;
  logic [1:0] r_fill;
  logic       r_armed;

  // Two-flop synchronizers; reset to an idle bus (cs=1, e=1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_meta   <= 1'b1;
      r_cs_s1     <= 1'b1;
      r_e_meta    <= 1'b1;
      r_e_s1      <= 1'b1;
      r_e_s2      <= 1'b1;
      r_rw_meta   <= 1'b0;
      r_rw_s1     <= 1'b0;
      r_dc_meta   <= 1'b0;
      r_dc_s1     <= 1'b0;
      r_data_meta <= 8'h00;
      r_data_s1   <= 8'h00;
    end else begin
      r_cs_meta   <= i_cs;
      r_cs_s1     <= r_cs_meta;
      r_e_meta    <= i_e;
      r_e_s1      <= r_e_meta;
      r_e_s2      <= r_e_s1;
      r_rw_meta   <= i_rw;
      r_rw_s1     <= r_rw_meta;
      r_dc_meta   <= i_dc;
      r_dc_s1     <= r_dc_meta;
      r_data_meta <= i_data;
      r_data_s1   <= r_data_meta;
    end
  end

  // Arm edge detection once a real (post-reset) high E has reached s1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & r_e_s1);
    end
  end

  assign o_strobe = r_armed & r_e_s2 & ~r_e_s1 & ~r_cs_s1 & ~r_rw_s1;
  assign o_dc     = r_dc_s1;
  assign o_data   = r_data_s1;
  assign o_cs_s1  = r_cs_s1;
  assign o_rw_s1  = r_rw_s1;
  assign o_e_s1   = r_e_s1;

endmodule

// File: rtl/oled_6800_rx.sv
// 6800-bus OLED write responder: parses SSD1306 command bytes and turns
// GDDRAM data bytes into frame-buffer writes addressed {page, col}.
// Optional status read-back is enabled by defining OLED_RX_READBACK_EN;
// without it rd_oe/rd_data are tied low and read strobes are ignored.
module oled_6800_rx
  import oled_pkg::*;
#(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 oled_cs,
  input  logic                                 oled_e,
  input  logic                                 oled_rw,
  input  logic                                 oled_dc,
  input  logic [7:0]                           oled_data,
  output logic                                 cmd_valid,
  output logic [7:0]                           cmd_opcode,
  output logic [7:0]                           cmd_arg,
  output logic                                 cmd_has_arg,
  output logic                                 wr_en,
  output logic [$clog2(PAGES)+$clog2(COLS)-1:0] wr_addr,
  output logic [7:0]                           wr_data,
  output logic                                 frame_done,
  output logic                                 display_on,
  output logic                                 proto_err,
  output logic [7:0]                           rd_data,
  output logic                                 rd_oe
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  logic       w_strobe, w_dc, w_cs_s1, w_rw_s1, w_e_s1;
  logic [7:0] w_byte;

  oled_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cs     (oled_cs),
    .i_e      (oled_e),
    .i_rw     (oled_rw),
    .i_dc     (oled_dc),
    .i_data   (oled_data),
    .o_strobe (w_strobe),
    .o_dc     (w_dc),
    .o_data   (w_byte),
    .o_cs_s1  (w_cs_s1),
    .o_rw_s1  (w_rw_s1),
    .o_e_s1   (w_e_s1)
  );

  state_t          r_state, w_state_next;
  logic [7:0]      r_pend_op, w_pend_next;
  logic [PW-1:0]   r_page, w_page_next;
  logic [CW-1:0]   r_col, w_col_next;
  logic [6:0]      w_col_ext;
  logic            r_cmd_valid, w_cmd_valid_next;
  logic [7:0]      r_cmd_opcode, w_opcode_next;
  logic [7:0]      r_cmd_arg, w_arg_next;
  logic            r_cmd_has_arg, w_has_arg_next;
  logic            r_wr_en, w_wr_en_next;
  logic [PW+CW-1:0] r_wr_addr, w_wr_addr_next;
  logic [7:0]      r_wr_data, w_wr_data_next;
  logic            r_frame_done, w_frame_done_next;
  logic            r_display_on, w_display_on_next;
  logic            r_proto_err, w_proto_err_next;

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CMD;
    else        r_state <= w_state_next;
  end

  // Next-state, command decode, side effects and write-pointer advance
  always_comb begin
    w_state_next      = r_state;
    w_pend_next       = r_pend_op;
    w_page_next       = r_page;
    w_col_next        = r_col;
    w_col_ext         = 7'(r_col);
    w_cmd_valid_next  = 1'b0;
    w_opcode_next     = r_cmd_opcode;
    w_arg_next        = r_cmd_arg;
    w_has_arg_next    = r_cmd_has_arg;
    w_wr_en_next      = 1'b0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_frame_done_next = 1'b0;
    w_display_on_next = r_display_on;
    w_proto_err_next  = 1'b0;
    if (w_strobe) begin
      if (w_dc) begin
        // A data byte always lands in the frame buffer; a pending opcode is dropped
        if (r_state == S_ARG) w_proto_err_next = 1'b1;
        w_state_next   = S_CMD;
        w_wr_en_next   = 1'b1;
        w_wr_addr_next = {r_page, r_col};
        w_wr_data_next = w_byte;
        if (r_col == COL_LAST) begin
          w_col_next = '0;
          if (r_page == PAGE_LAST) begin
            w_page_next       = '0;
            w_frame_done_next = 1'b1;
          end else begin
            w_page_next = r_page + PW'(1);
          end
        end else begin
          w_col_next = r_col + CW'(1);
        end
      end else if (r_state == S_ARG) begin
        w_cmd_valid_next = 1'b1;
        w_opcode_next    = r_pend_op;
        w_arg_next       = w_byte;
        w_has_arg_next   = 1'b1;
        w_state_next     = S_CMD;
      end else if (has_arg(w_byte)) begin
        w_pend_next  = w_byte;
        w_state_next = S_ARG;
      end else begin
        w_cmd_valid_next = 1'b1;
        w_opcode_next    = w_byte;
        w_arg_next       = 8'h00;
        w_has_arg_next   = 1'b0;
        if (w_byte[7:4] == CMD_COL_LO[7:4]) begin
          w_col_ext[3:0] = w_byte[3:0];
          w_col_next     = CW'(w_col_ext);
        end else if (w_byte[7:3] == CMD_COL_HI[7:3]) begin
          w_col_ext[6:4] = w_byte[2:0];
          w_col_next     = CW'(w_col_ext);
        end else if (w_byte[7:3] == CMD_SET_PAGE[7:3]) begin
          w_page_next = PW'(w_byte[2:0]);
        end else if (w_byte == CMD_DISP_OFF) begin
          w_display_on_next = 1'b0;
        end else if (w_byte == CMD_DISP_ON) begin
          w_display_on_next = 1'b1;
        end
      end
    end
  end

  // Registered outputs and address pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_op     <= 8'h00;
      r_page        <= '0;
      r_col         <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_opcode  <= 8'h00;
      r_cmd_arg     <= 8'h00;
      r_cmd_has_arg <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 8'h00;
      r_frame_done  <= 1'b0;
      r_display_on  <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_pend_op     <= w_pend_next;
      r_page        <= w_page_next;
      r_col         <= w_col_next;
      r_cmd_valid   <= w_cmd_valid_next;
      r_cmd_opcode  <= w_opcode_next;
      r_cmd_arg     <= w_arg_next;
      r_cmd_has_arg <= w_has_arg_next;
      r_wr_en       <= w_wr_en_next;
      r_wr_addr     <= w_wr_addr_next;
      r_wr_data     <= w_wr_data_next;
      r_frame_done  <= w_frame_done_next;
      r_display_on  <= w_display_on_next;
      r_proto_err   <= w_proto_err_next;
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_opcode  = r_cmd_opcode;
  assign cmd_arg     = r_cmd_arg;
  assign cmd_has_arg = r_cmd_has_arg;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_done  = r_frame_done;
  assign display_on  = r_display_on;
  assign proto_err   = r_proto_err;

`ifdef OLED_RX_READBACK_EN
  logic       r_rd_oe;
  logic [7:0] r_rd_data;

  // Status driven while the host holds a read cycle open (cs low, rw high, E high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_oe   <= 1'b0;
      r_rd_data <= 8'h00;
    end else if (!w_cs_s1 && w_rw_s1 && w_e_s1) begin
      r_rd_oe   <= 1'b1;
      r_rd_data <= {~r_display_on, (r_state == S_ARG), 3'b000, 3'(r_page)};
    end else begin
      r_rd_oe   <= 1'b0;
      r_rd_data <= 8'h00;
    end
  end

  assign rd_oe   = r_rd_oe;
  assign rd_data = r_rd_data;
`else
  logic w_unused_rb;
  assign w_unused_rb = ^{w_cs_s1, w_rw_s1, w_e_s1};
  assign rd_oe       = 1'b0;
  assign rd_data     = 8'h00;
`endif

endmodule

// File: tb/tb_oled_6800_rx.sv
// Self-checking bench for oled_6800_rx: directed table, latency, full-frame,
// read-back, reset-mid-byte and randomized traffic against a pointer model.
module tb_oled_6800_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       oled_cs = 1'b1, oled_e = 1'b1, oled_rw = 1'b0, oled_dc = 1'b0;
  logic [7:0] oled_data = 8'h00;
  logic       cmd_valid, cmd_has_arg, wr_en, frame_done, display_on, proto_err, rd_oe;
  logic [7:0] cmd_opcode, cmd_arg, wr_data, rd_data;
  logic [9:0] wr_addr;

  always #10 clk = ~clk;

  oled_6800_rx dut (
    .clk(clk), .rst_n(rst_n), .oled_cs(oled_cs), .oled_e(oled_e), .oled_rw(oled_rw),
    .oled_dc(oled_dc), .oled_data(oled_data), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_arg(cmd_arg), .cmd_has_arg(cmd_has_arg), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .display_on(display_on),
    .proto_err(proto_err), .rd_data(rd_data), .rd_oe(rd_oe)
  );

  typedef struct {
    logic       dc;
    logic [7:0] b;
    int         ncmd;
    logic [7:0] op;
    logic [7:0] arg;
    logic       has;
    int         nwr;
    logic [9:0] addr;
    logic [7:0] data;
    int         nfd;
    int         nperr;
    logic       disp;
  } vec_t;

  int n_pass = 0, n_total = 0;

  // Pulse monitor: counts every output pulse, remembers the latest payloads
  int cnt_cmd = 0, cnt_wr = 0, cnt_fd = 0, cnt_perr = 0;
  logic [7:0] last_op = 0, last_arg = 0, last_wdata = 0;
  logic       last_has = 0;
  logic [9:0] last_addr = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        cnt_cmd  <= cnt_cmd + 1;
        last_op  <= cmd_opcode;
        last_arg <= cmd_arg;
        last_has <= cmd_has_arg;
      end
      if (wr_en) begin
        cnt_wr     <= cnt_wr + 1;
        last_addr  <= wr_addr;
        last_wdata <= wr_data;
      end
      if (frame_done) cnt_fd   <= cnt_fd + 1;
      if (proto_err)  cnt_perr <= cnt_perr + 1;
    end
  end

  // Reference model: linear frame pointer, pending opcode (-1 = none), display flag
  int m_ptr = 0, m_pend = -1;
  bit m_disp = 0;

  function automatic void model_reset();
    m_ptr = 0; m_pend = -1; m_disp = 0;
  endfunction

  function automatic vec_t model_step(input logic dc, input logic [7:0] b);
    vec_t v;
    int pg, col;
    v.dc = dc; v.b = b; v.ncmd = 0; v.op = 0; v.arg = 0; v.has = 0;
    v.nwr = 0; v.addr = 0; v.data = 0; v.nfd = 0; v.nperr = 0;
    if (dc) begin
      if (m_pend >= 0) v.nperr = 1;
      m_pend = -1;
      v.nwr = 1; v.addr = 10'(m_ptr); v.data = b;
      v.nfd = (m_ptr == 1023) ? 1 : 0;
      m_ptr = (m_ptr + 1) % 1024;
    end else if (m_pend >= 0) begin
      v.ncmd = 1; v.op = 8'(m_pend); v.arg = b; v.has = 1;
      m_pend = -1;
    end else if (b inside {8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'hDA, 8'h81, 8'hD9, 8'hDB}) begin
      m_pend = int'(b);
    end else begin
      v.ncmd = 1; v.op = b;
      pg = m_ptr / 128; col = m_ptr % 128;
      if (b < 8'h10) col = (col / 16) * 16 + int'(b);
      else if (b < 8'h18) col = (col % 16) + (int'(b) - 16) * 16;
      else if (b >= 8'hB0 && b <= 8'hB7) pg = int'(b) - 'hB0;
      else if (b == 8'hAE) m_disp = 0;
      else if (b == 8'hAF) m_disp = 1;
      m_ptr = pg * 128 + col;
    end
    v.disp = m_disp;
    return v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%0h want=%0h", name, got, want);
  endfunction

  // One 6800 write/read-cycle framing: address phase, E low 2 clk, E high, release
  task automatic xfer(input logic dc, input logic [7:0] b);
    @(negedge clk); oled_cs = 1'b0; oled_rw = 1'b0; oled_dc = dc; oled_data = b;
    @(negedge clk); oled_e = 1'b0;
    @(negedge clk); @(negedge clk); oled_e = 1'b1;
    @(negedge clk); oled_cs = 1'b1;
  endtask

  task automatic send_chk(input string tag, input vec_t v);
    int c0, w0, f0, p0;
    c0 = cnt_cmd; w0 = cnt_wr; f0 = cnt_fd; p0 = cnt_perr;
    xfer(v.dc, v.b);
    repeat (3) @(negedge clk);
    $display("%s dc=%0d byte=%02h cmd=%0d wr=%0d addr=%03h", tag, v.dc, v.b,
             cnt_cmd - c0, cnt_wr - w0, last_addr);
    chk({tag, ".ncmd"}, cnt_cmd - c0, v.ncmd);
    if (v.ncmd > 0) begin
      chk({tag, ".op"}, last_op, v.op);
      chk({tag, ".arg"}, last_arg, v.arg);
      chk({tag, ".has"}, last_has, v.has);
    end
    chk({tag, ".nwr"}, cnt_wr - w0, v.nwr);
    if (v.nwr > 0) begin
      chk({tag, ".addr"}, last_addr, v.addr);
      chk({tag, ".data"}, last_wdata, v.data);
    end
    chk({tag, ".nfd"}, cnt_fd - f0, v.nfd);
    chk({tag, ".nperr"}, cnt_perr - p0, v.nperr);
    chk({tag, ".disp"}, display_on, v.disp);
  endtask

  // Read cycle; E is also pulsed low with rw=1, which must not produce a strobe
  task automatic read_chk(input string tag);
    int c0, w0;
    logic [7:0] want;
    logic [2:0] pg;
    pg = 3'(m_ptr / 128);
    want = {~m_disp, (m_pend >= 0), 3'b000, pg};
    c0 = cnt_cmd; w0 = cnt_wr;
    @(negedge clk); oled_cs = 1'b0; oled_rw = 1'b1; oled_dc = 1'($urandom); oled_data = 8'($urandom);
    repeat (3) @(negedge clk);
    $display("%s read rd_oe=%0d rd_data=%02h", tag, rd_oe, rd_data);
`ifdef OLED_RX_READBACK_EN
    chk({tag, ".rd_oe"}, rd_oe, 1);
    chk({tag, ".rd_data"}, rd_data, want);
`else
    chk({tag, ".rd_oe"}, rd_oe, 0);
    chk({tag, ".rd_data"}, rd_data, 0);
    if (want === 8'hxx) $display("note: status unused");
`endif
    oled_e = 1'b0;
    repeat (2) @(negedge clk);
    oled_e = 1'b1;
    @(negedge clk); oled_cs = 1'b1; oled_rw = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, ".rd_oe_off"}, rd_oe, 0);
    chk({tag, ".rd_ncmd"}, cnt_cmd - c0, 0);
    chk({tag, ".rd_nwr"}, cnt_wr - w0, 0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[14];
  vec_t v, dummy;
  logic [7:0] arg_ops[8] = '{8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'hDA, 8'h81, 8'hD9, 8'hDB};

  initial begin
    int c0, w0;
    logic [7:0] b;
    logic dc;

    //        dc  byte   ncmd op     arg    has nwr addr    data   nfd nperr disp
    tbl[0]  = '{0, 8'hAE, 1, 8'hAE, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 8'hD5, 0, 8'h00, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 0};
    tbl[2]  = '{0, 8'h80, 1, 8'hD5, 8'h80, 1,  0, 10'h000, 8'h00, 0, 0, 0};
    tbl[3]  = '{0, 8'hAF, 1, 8'hAF, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[4]  = '{0, 8'h81, 0, 8'h00, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[5]  = '{1, 8'h55, 0, 8'h00, 8'h00, 0,  1, 10'h000, 8'h55, 0, 1, 1};
    tbl[6]  = '{0, 8'hB3, 1, 8'hB3, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[7]  = '{0, 8'h05, 1, 8'h05, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[8]  = '{0, 8'h12, 1, 8'h12, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[9]  = '{1, 8'hFF, 0, 8'h00, 8'h00, 0,  1, 10'h1A5, 8'hFF, 0, 0, 1};
    tbl[10] = '{1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 10'h1A6, 8'h00, 0, 0, 1};
    tbl[11] = '{0, 8'hB0, 1, 8'hB0, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[12] = '{0, 8'h00, 1, 8'h00, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};
    tbl[13] = '{0, 8'h10, 1, 8'h10, 8'h00, 0,  0, 10'h000, 8'h00, 0, 0, 1};

    // Reset, then 100 idle clocks: no pulses, every output still zero
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (100) @(negedge clk);
    chk("idle.ncmd", cnt_cmd, 0);
    chk("idle.nwr", cnt_wr, 0);
    chk("idle.cmd_valid", cmd_valid, 0);
    chk("idle.cmd_opcode", cmd_opcode, 0);
    chk("idle.cmd_arg", cmd_arg, 0);
    chk("idle.cmd_has_arg", cmd_has_arg, 0);
    chk("idle.wr_en", wr_en, 0);
    chk("idle.wr_addr", wr_addr, 0);
    chk("idle.wr_data", wr_data, 0);
    chk("idle.frame_done", frame_done, 0);
    chk("idle.display_on", display_on, 0);
    chk("idle.proto_err", proto_err, 0);
    chk("idle.rd_oe", rd_oe, 0);
    chk("idle.rd_data", rd_data, 0);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      dummy = model_step(tbl[i].dc, tbl[i].b);
      send_chk($sformatf("tbl%0d", i), tbl[i]);
    end

    // Latency: E sampled low at edge N -> cmd_valid only in the cycle after N+2
    c0 = cnt_cmd;
    @(negedge clk); oled_cs = 1'b0; oled_rw = 1'b0; oled_dc = 1'b0; oled_data = 8'hE3;
    @(negedge clk); oled_e = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("lat.n1", cmd_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("lat.n2", cmd_valid, 1);
    chk("lat.op", cmd_opcode, 8'hE3);
    @(posedge clk); @(negedge clk);
    chk("lat.n3", cmd_valid, 0);
    oled_e = 1'b1;
    repeat (2) @(negedge clk);
    oled_cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat.count", cnt_cmd - c0, 1);
    dummy = model_step(1'b0, 8'hE3);
    $display("latency byte=E3 cmd=%0d", cnt_cmd - c0);

    // Full frame from 0/0: addresses 0..1023, frame_done on the last, then back to 0
    for (int i = 0; i <= 1024; i++) begin
      b = 8'($urandom);
      dummy = model_step(1'b1, b);
      v = '{1'b1, b, 0, 8'h00, 8'h00, 1'b0, 1, 10'(i % 1024), b, (i == 1023) ? 1 : 0, 0, 1'b1};
      send_chk($sformatf("frm%0d", i), v);
    end

    // Display on, then read back status
    v = model_step(1'b0, 8'hAF);
    send_chk("rb.af", v);
    read_chk("rb");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        read_chk($sformatf("rnd%0d", i));
      end else begin
        dc = (r < 5);
        if (dc) b = 8'($urandom);
        else begin
          case ($urandom_range(0, 3))
            0: b = arg_ops[$urandom_range(0, 7)];
            1: case ($urandom_range(0, 3))
                 0: b = 8'($urandom_range(8'h00, 8'h0F));
                 1: b = 8'($urandom_range(8'h10, 8'h17));
                 2: b = 8'($urandom_range(8'hB0, 8'hB7));
                 default: b = ($urandom_range(0, 1) == 1) ? 8'hAF : 8'hAE;
               endcase
            default: b = 8'($urandom);
          endcase
        end
        v = model_step(dc, b);
        send_chk($sformatf("rnd%0d", i), v);
      end
    end

    // Reset asserted mid-byte with E held low: no pulse until a fresh falling edge
    c0 = cnt_cmd; w0 = cnt_wr;
    @(negedge clk); oled_cs = 1'b0; oled_rw = 1'b0; oled_dc = 1'b1; oled_data = 8'hAA;
    @(negedge clk); oled_e = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    oled_e = 1'b1;
    repeat (4) @(negedge clk);
    oled_cs = 1'b1;
    repeat (2) @(negedge clk);
    $display("midreset cmd=%0d wr=%0d", cnt_cmd - c0, cnt_wr - w0);
    chk("rst.ncmd", cnt_cmd - c0, 0);
    chk("rst.nwr", cnt_wr - w0, 0);
    chk("rst.display_on", display_on, 0);
    v = model_step(1'b1, 8'h3C);
    send_chk("rst.after", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
